// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one FP32 adder/subtractor among N_REQ requesters.
// Each operation: accept in IDLE, one EXEC cycle, then hold the result in RESP.

module fp_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);
    logic        sa, sb, sx, sy, swap;
    logic [7:0]  ea, eb, ex, ey, d;
    logic [23:0] ma, mb, mx, my, mf;
    logic [4:0]  sh_amt, lz;
    logic [49:0] sh;
    logic [26:0] al, nm;
    logic [27:0] s;
    logic [24:0] mr;
    logic signed [9:0] ne, ef;
    logic        inc, nan_a, nan_b, inf_a, inf_b;

    // Align, add/subtract magnitudes, normalise, round to nearest even.
    // Subnormal inputs are flushed to zero; underflow flushes to signed zero.
    always_comb begin
        sa = a[31];
        sb = b[31] ^ sub;
        ea = a[30:23];
        eb = b[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        swap = {eb, mb} > {ea, ma};
        sx = swap ? sb : sa;
        sy = swap ? sa : sb;
        ex = swap ? eb : ea;
        ey = swap ? ea : eb;
        mx = swap ? mb : ma;
        my = swap ? ma : mb;
        d = ex - ey;
        sh_amt = (d > 8'd31) ? 5'd31 : d[4:0];
        sh = {my, 26'd0} >> sh_amt;
        al = {sh[49:24], |sh[23:0]};
        if (sx == sy)
            s = {1'b0, mx, 3'd0} + {1'b0, al};
        else
            s = {1'b0, mx, 3'd0} - {1'b0, al};
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (s[i]) lz = 5'(26 - i);
        if (s[27]) begin
            nm = {s[27:2], s[1] | s[0]};
            ne = $signed({2'b00, ex}) + 10'sd1;
        end else begin
            nm = s[26:0] << lz;
            ne = $signed({2'b00, ex}) - $signed({5'd0, lz});
        end
        inc = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr = {1'b0, nm[26:3]} + {24'd0, inc};
        mf = mr[24] ? mr[24:1] : mr[23:0];
        ef = mr[24] ? ne + 10'sd1 : ne;
        nan_a = (ea == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (eb == 8'hFF) && (b[22:0] != 23'd0);
        inf_a = (ea == 8'hFF) && (a[22:0] == 23'd0);
        inf_b = (eb == 8'hFF) && (b[22:0] == 23'd0);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            result = 32'h7FC0_0000;
        else if (inf_a)
            result = {sa, 8'hFF, 23'd0};
        else if (inf_b)
            result = {sb, 8'hFF, 23'd0};
        else if (s == 28'd0)
            result = {sa & sb, 31'd0};
        else if (ef <= 10'sd0)
            result = {sx, 31'd0};
        else if (ef >= 10'sd255)
            result = {sx, 8'hFF, 23'd0};
        else
            result = {sx, ef[7:0], mf[22:0]};
    end
endmodule

module fp_addsub_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_sub,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic [PTR_W-1:0]      owner
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [PTR_W-1:0] ptr, win, ptr_nx;
    logic             found, accept, done;
    logic [31:0]      op_a, op_b, result_reg, fp_result;
    logic             op_sub;
    int               j;

    fp_addsub u_fp (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .result (fp_result)
    );

    // Round-robin search starting at ptr for the first valid requester.
    always_comb begin
        win = ptr;
        found = 1'b0;
        j = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req_valid[j]) begin
                win = PTR_W'(j);
                found = 1'b1;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nx = state;
        req_ready = '0;
        rsp_valid = '0;
        accept = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready[win] = found;
                accept = found;
                if (found) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ptr_nx = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
    assign busy = (state != IDLE);
    assign rsp_data = result_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand capture, result register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            result_reg <= '0;
        end else begin
            if (accept) begin
                op_a   <= req_a[32*win +: 32];
                op_b   <= req_b[32*win +: 32];
                op_sub <= req_sub[win];
                owner  <= win;
            end
            if (state == EXEC) result_reg <= fp_result;
            if (done) ptr <= ptr_nx;
        end
    end
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomised bench with a behavioural model of the shared FP32 adder arbiter.
// Operands are small integers so every expected sum is exact.

module tb_fp_addsub_arbiter;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [31:0]    rsp_data;
    logic           busy;
    logic [1:0]     owner;

    fp_addsub_arbiter #(.N_REQ(N), .PTR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          pend;
    int          age;
    int          m_owner, m_ptr;
    logic [31:0] m_res, m_data;
    logic [31:0] exp_r [N];
    int          cyc_n;
    int          gq_idx[$];
    int          gq_cyc[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, time %0t limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] int2fp(input int v);
        int unsigned mag;
        int          p;
        logic [31:0] m;
        logic [7:0]  e;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? int'(-v) : v;
        p = 0;
        for (int i = 0; i < 31; i++)
            if (mag[i]) p = i;
        m = mag << (31 - p);
        e = 8'(127 + p);
        return {(v < 0), e, m[30:8]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc_n);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b, input bit s);
        req_a[32*i +: 32] = int2fp(a);
        req_b[32*i +: 32] = int2fp(b);
        req_sub[i] = s;
        exp_r[i] = int2fp(s ? a - b : a + b);
    endtask

    task automatic set_raw(input int i, input logic [31:0] a,
                           input logic [31:0] b, input bit s,
                           input logic [31:0] r);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i] = s;
        exp_r[i] = r;
    endtask

    task automatic settle();
        logic [N-1:0] e_rdy, e_vld;
        int w;
        #1;
        if (!rst_n) begin
            pend = 0;
            m_ptr = 0;
            m_owner = 0;
            m_data = 32'd0;
        end
        e_rdy = '0;
        e_vld = '0;
        if (!pend && req_valid != '0) begin
            w = winner();
            e_rdy[w] = 1'b1;
        end
        if (pend && age >= 2) e_vld[m_owner] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
        chk("rsp_data", rsp_data, m_data);
        chk("busy", 32'(busy), 32'(pend));
        chk("owner", 32'(owner), 32'(m_owner));
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
                gq_idx.push_back(i);
                gq_cyc.push_back(cyc_n);
            end
    endtask

    task automatic edge_step();
        int w;
        if (rst_n) begin
            if (!pend) begin
                if (req_valid != '0) begin
                    w = winner();
                    pend = 1;
                    age = 1;
                    m_owner = w;
                    m_res = exp_r[w];
                end
            end else if (age == 1) begin
                age = 2;
                m_data = m_res;
            end else if (rsp_ready[m_owner]) begin
                pend = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic run_op(input int i, input logic [31:0] r);
        req_valid = 4'(1 << i);
        rsp_ready = 4'(1 << i);
        settle();
        chk("op_ready", 32'(req_ready), 32'(1 << i));
        edge_step();
        req_valid = '0;
        settle();
        chk("op_exec_vld", 32'(rsp_valid), 32'd0);
        edge_step();
        settle();
        chk("op_rsp_vld", 32'(rsp_valid), 32'(1 << i));
        chk("op_rsp_data", rsp_data, r);
        chk("op_owner", 32'(owner), 32'(i));
        edge_step();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sub = '0;
        rsp_ready = '0;
        cyc_n = 0;
        pend = 0;
        age = 0;
        m_owner = 0;
        m_ptr = 0;
        m_res = 32'd0;
        m_data = 32'd0;
        for (int i = 0; i < N; i++) exp_r[i] = 32'd0;

        chk("model_one", int2fp(1), 32'h3F80_0000);
        chk("model_neg6", int2fp(-6), 32'hC0C0_0000);
        chk("model_zero", int2fp(0), 32'h0000_0000);

        @(negedge clk);
        settle();
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        edge_step();
        rst_n = 1'b1;

        set_req(0, 1, 2, 1'b0);
        run_op(0, 32'h4040_0000);
        set_req(2, 3, 1, 1'b1);
        run_op(2, 32'h4000_0000);

        rst_n = 1'b0;
        settle();
        chk("rst_idle_owner", 32'(owner), 32'd0);
        edge_step();
        rst_n = 1'b1;

        for (int i = 0; i < N; i++)
            set_req(i, int'($urandom_range(0, 2000)) - 1000,
                    int'($urandom_range(0, 2000)) - 1000, 1'($urandom));
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        gq_idx.delete();
        gq_cyc.delete();
        for (int n = 0; n < 15; n++) begin
            settle();
            edge_step();
        end
        chk("fair_count", 32'(gq_idx.size()), 32'd5);
        if (gq_idx.size() >= 5)
            for (int k = 0; k < 5; k++) begin
                chk("fair_idx", 32'(gq_idx[k]), 32'(k % N));
                if (k > 0)
                    chk("fair_gap", 32'(gq_cyc[k] - gq_cyc[k-1]), 32'd3);
            end

        req_valid = 4'b0010;
        set_req(1, 5, 7, 1'b0);
        rsp_ready = 4'b0000;
        settle();
        chk("bp_ready", 32'(req_ready), 32'b0010);
        edge_step();
        req_valid = 4'b1111;
        settle();
        edge_step();
        for (int n = 0; n < 5; n++) begin
            settle();
            chk("bp_vld", 32'(rsp_valid), 32'b0010);
            chk("bp_data", rsp_data, 32'h4140_0000);
            chk("bp_rdy0", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            edge_step();
        end
        rsp_ready = 4'b0010;
        req_valid = '0;
        settle();
        chk("bp_last_vld", 32'(rsp_valid), 32'b0010);
        edge_step();
        settle();
        chk("bp_done_busy", 32'(busy), 32'd0);
        edge_step();

        req_valid = 4'b0010;
        set_req(1, 10, -3, 1'b1);
        rsp_ready = 4'b0000;
        settle();
        edge_step();
        req_valid = '0;
        settle();
        edge_step();
        rsp_ready = 4'b1101;
        for (int n = 0; n < 3; n++) begin
            settle();
            chk("wr_vld", 32'(rsp_valid), 32'b0010);
            chk("wr_busy", 32'(busy), 32'd1);
            edge_step();
        end
        rsp_ready = 4'b0010;
        settle();
        chk("wr_data", rsp_data, 32'h4150_0000);
        edge_step();
        settle();
        chk("wr_done_busy", 32'(busy), 32'd0);
        edge_step();

        set_req(0, 9, 4, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        settle();
        edge_step();
        req_valid = '0;
        rst_n = 1'b0;
        settle();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        edge_step();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            settle();
            chk("post_rst_vld", 32'(rsp_valid), 32'd0);
            edge_step();
        end

        set_raw(3, 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
        run_op(3, 32'h3F80_0000);
        set_raw(3, 32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001);
        run_op(3, 32'h3F80_0001);

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            req_valid = 4'($urandom) & 4'($urandom | $urandom);
            for (int i = 0; i < N; i++)
                set_req(i, int'($urandom_range(0, 8192)) - 4096,
                        int'($urandom_range(0, 8192)) - 4096, 1'($urandom));
            rsp_ready = 4'($urandom) | 4'($urandom);
            settle();
            edge_step();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one fp_addsub instance (legal 2..8).
REQ-002 SHALL have parameter PTR_W, default 2, width of grant index; equals clog2(N_REQ).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept; at most one bit high.
REQ-007 SHALL have port req_a  input  32*N_REQ  FP32 operand A, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_b  input  32*N_REQ  FP32 operand B, same packing.
REQ-009 SHALL have port req_sub  input  N_REQ  1 = A-B, 0 = A+B.
REQ-010 SHALL have port rsp_valid  output  N_REQ  result available to requester i; at most one bit high.
REQ-011 SHALL have port rsp_ready  input  N_REQ  requester i consumes result.
REQ-012 SHALL have port rsp_data  output  32  shared FP32 result bus.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port owner  output  PTR_W  index of requester currently being served.

Function
REQ-015 SHALL instantiate exactly one fp_addsub (ports a, b, sub, result), fed only from internal operand registers op_a, op_b, op_sub.
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other reachable states; illegal encodings go to IDLE.
REQ-017 IDLE: req_ready[w] = 1 combinationally for winner w only when any req_valid high; all other req_ready = 0; req_ready = 0 in EXEC and RESP.
REQ-018 Winner w = first i with req_valid[i]=1 searching ptr, ptr+1, ... wrapping modulo N_REQ.
REQ-019 On accept edge (IDLE, req_valid[w]): op_a, op_b, op_sub <= requester w fields; owner <= w; state <= EXEC.
REQ-020 EXEC (exactly one cycle): result_reg <= fp_addsub result; state <= RESP.
REQ-021 RESP: rsp_valid[owner] = 1, rsp_data = result_reg; hold until rsp_ready[owner]=1, then state <= IDLE, ptr <= (owner+1) mod N_REQ.
REQ-022 Latency: accept at edge T -> rsp_valid high from T+2; minimum 3 cycles per operation.
REQ-023 rsp_ready of non-owner requesters SHALL be ignored; rsp_data and rsp_valid SHALL be stable while stalled in RESP.
REQ-024 req_valid deasserting in IDLE before accept SHALL not be an error; winner recomputed each cycle.
REQ-025 New requests arriving during EXEC/RESP SHALL wait; no request accepted until return to IDLE.
REQ-026 rsp_data SHALL hold last result_reg value in IDLE (not cleared).
REQ-027 ptr SHALL only advance on response completion, never on idle cycles, guaranteeing no starvation within N_REQ operations.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, ptr=0, owner=0, op_a=op_b=0, op_sub=0, result_reg=0; rsp_valid=0, busy=0, rsp_data=0.
REQ-029 Reset asserted during EXEC or RESP SHALL discard the in-flight operation; no response issued after release.
REQ-030 First accept after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-031 Single op: req_valid=0001, a=0x3F800000, b=0x40000000, sub=0 -> req_ready=0001 at T, rsp_valid=0001 at T+2, rsp_data=0x40400000.
REQ-032 Subtract: requester 2, a=0x40400000, b=0x3F800000, sub=1 -> rsp_valid=0100, rsp_data=0x40000000, owner=2.
REQ-033 Fairness: req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0 with one accept every 3 cycles; ptr wraps 3->0.
REQ-034 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0000 throughout, busy=1; completes on first rsp_ready[owner]=1.
REQ-035 Wrong-ready: owner=1, rsp_ready=1101 -> remains in RESP; only rsp_ready[1] completes.
REQ-036 Reset mid-op: assert rst_n=0 during EXEC -> all outputs reset values immediately; no rsp_valid after release until a new accept.
